mem_responder: RTL and testbench

- Memory-side responder for the cache-to-memory line interface; the other end of the instruction/data cache miss path.
- Accepts one line read (fill) or line write (writeback) request at a time over a valid/ready handshake.
- Returns the response after a fixed, parameterised latency, holding it until the cache accepts it.
- Replaces the per-word combinational memory path with a line-granular, latency-accurate backing store for the pipelined core.

---
 rtl/mem_if_pkg.sv | 22 ++
 rtl/mem_line_array.sv | 34 +++
 rtl/mem_responder.sv | 130 +++++++++++++
 tb/tb_mem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types for the cache-to-memory line interface (cache and memory sides).
// Line width, FSM state names and the request bundle live here.
package mem_if_pkg;

    localparam int WORD_BITS      = 32;
    localparam int DEF_LINE_WORDS = 4;

    typedef logic [WORD_BITS*DEF_LINE_WORDS-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        line_t       wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_line_array.sv
// Single-port synchronous line storage with a registered read, built as one
// word-wide array per line word so each lane maps onto its own block RAM.
module mem_line_array
    import mem_if_pkg::*;
#(
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int DEPTH_LINES = 1024,
    parameter int IDX_BITS    = $clog2(DEPTH_LINES)
) (
    input  logic                            clock,
    input  logic                            we,
    input  logic [IDX_BITS-1:0]             idx,
    input  logic [WORD_BITS*LINE_WORDS-1:0] wdata,
    output logic [WORD_BITS*LINE_WORDS-1:0] rdata
);

    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            logic [WORD_BITS-1:0] mem [DEPTH_LINES];
            logic [WORD_BITS-1:0] rdata_reg;

            // Read-first: the read port returns the pre-write contents.
            always_ff @(posedge clock) begin
                if (we) begin
                    mem[idx] <= wdata[gi*WORD_BITS +: WORD_BITS];
                end
                rdata_reg <= mem[idx];
            end

            assign rdata[gi*WORD_BITS +: WORD_BITS] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Line-granular memory responder: one outstanding fill/writeback, fixed latency.
// Optional MEM_RANGE_CHECK_EN flags (and suppresses) accesses beyond the array.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int LATENCY     = 5,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int DEPTH_LINES = 1024
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [31:0]                     req_addr,
    input  logic [WORD_BITS*LINE_WORDS-1:0] req_wdata,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic                            resp_write,
    output logic [WORD_BITS*LINE_WORDS-1:0] resp_rdata,
    output logic                            resp_error
);

    localparam int LINE_BITS = WORD_BITS * LINE_WORDS;
    localparam int OFS       = $clog2(4 * LINE_WORDS);
    localparam int IDX       = $clog2(DEPTH_LINES);

    mem_state_e             state_reg;
    logic [7:0]             count_reg;
    logic                   write_reg;
    logic                   error_reg;
    logic [IDX-1:0]         idx_reg;
    logic                   req_ready_reg;
    logic                   resp_valid_reg;
    logic                   resp_write_reg;
    logic [LINE_BITS-1:0]   resp_rdata_reg;
    logic                   resp_error_reg;

    logic [IDX-1:0]         req_idx;
    logic                   in_range;
    logic                   accept;
    logic                   ram_we;
    logic [IDX-1:0]         ram_idx;
    logic [LINE_BITS-1:0]   ram_rdata;
    logic                   unused_addr;

    assign req_idx     = req_addr[OFS +: IDX];
    assign unused_addr = ^req_addr;

`ifdef MEM_RANGE_CHECK_EN
    assign in_range = (req_addr >> (OFS + IDX)) == 32'd0;
`else
    assign in_range = 1'b1;
`endif

    assign accept  = req_ready_reg && req_valid;
    assign ram_we  = accept && req_write && in_range;
    // In IDLE the array is already reading the incoming index, so a read is
    // available by the time the counter expires even when LATENCY is 1.
    assign ram_idx = (state_reg == IDLE) ? req_idx : idx_reg;

    mem_line_array #(
        .LINE_WORDS  (LINE_WORDS),
        .DEPTH_LINES (DEPTH_LINES),
        .IDX_BITS    (IDX)
    ) u_array (
        .clock (clock),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= 8'd0;
            write_reg      <= 1'b0;
            error_reg      <= 1'b0;
            idx_reg        <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_write_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_error_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        write_reg     <= req_write;
                        error_reg     <= ~in_range;
                        idx_reg       <= req_idx;
                        count_reg     <= 8'(LATENCY - 1);
                        req_ready_reg <= 1'b0;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    if (count_reg == 8'd0) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_write_reg <= write_reg;
                        resp_error_reg <= error_reg;
                        resp_rdata_reg <= (write_reg || error_reg) ? '0 : ram_rdata;
                    end else begin
                        count_reg <= count_reg - 8'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_write = resp_write_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_error = resp_error_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a LATENCY=5 instance checked every cycle
// against a line-level model, plus a LATENCY=1 instance run back-to-back.
module tb_mem_responder;

    localparam int LAT = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset;
    logic         req_valid, req_ready, req_write;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic         resp_valid, resp_ready, resp_write, resp_error;
    logic [127:0] resp_rdata;

    logic         b_req_valid, b_req_ready, b_req_write;
    logic [31:0]  b_req_addr;
    logic [127:0] b_req_wdata;
    logic         b_resp_valid, b_resp_ready, b_resp_write, b_resp_error;
    logic [127:0] b_resp_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit done1  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    mem_responder #(.LATENCY(LAT), .LINE_WORDS(4), .DEPTH_LINES(1024)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    mem_responder #(.LATENCY(1), .LINE_WORDS(4), .DEPTH_LINES(1024)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_write(b_resp_write),
        .resp_rdata(b_resp_rdata), .resp_error(b_resp_error)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- line-level reference model ----------------
    logic [127:0] model_mem [int];

    function automatic int line_idx(input logic [31:0] a);
        return int'((a / 32'd16) % 32'd1024);
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return a < 32'd16384;
`else
        return 1'b1;
`endif
    endfunction

    bit           m_busy = 0;
    int           m_acc  = 0;
    int           m_cyc  = 0;
    bit           m_w, m_err, m_rv;
    logic [127:0] m_line;

    // Outputs sampled mid-cycle; a request seen here is accepted at the next edge
    // and its response must be visible LAT edges later, until it is taken.
    always @(negedge clock) begin
        if (reset) begin
            m_busy = 0;
        end else if (m_busy) begin
            m_rv = (m_cyc >= m_acc + LAT + 1);
            check("mon_req_ready_busy", req_ready, 1'b0);
            check("mon_resp_valid", resp_valid, m_rv);
            if (m_rv) begin
                check("mon_resp_write", resp_write, m_w);
                check("mon_resp_rdata", resp_rdata, m_line);
                check("mon_resp_error", resp_error, m_err);
                if (resp_ready) m_busy = 0;
            end
        end else begin
            check("mon_req_ready_idle", req_ready, 1'b1);
            check("mon_resp_valid_idle", resp_valid, 1'b0);
            if (req_valid) begin
                m_busy = 1;
                m_acc  = m_cyc;
                m_w    = req_write;
                m_err  = !addr_ok(req_addr);
                if (req_write) begin
                    if (addr_ok(req_addr)) model_mem[line_idx(req_addr)] = req_wdata;
                    m_line = '0;
                end else if (addr_ok(req_addr) && model_mem.exists(line_idx(req_addr))) begin
                    m_line = model_mem[line_idx(req_addr)];
                end else begin
                    m_line = '0;
                end
            end
        end
        m_cyc++;
    end

    // ---------------- directed transactions on the LATENCY=5 instance ----------------
    task automatic transact(input bit w, input logic [31:0] a, input logic [127:0] d,
                            input logic [127:0] exp_d, input bit exp_e, input int hold,
                            input string name);
        int n;
        int lat;
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clock); #1; n++;
        end
        check({name, "_accept_wait"}, (n < 50), 1'b1);
        @(posedge clock); #1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = '0;
        lat = 0;
        while (!resp_valid && lat < 300) begin
            @(posedge clock); #1; lat++;
        end
        $display("txn %-14s %s addr=%08h lat=%0d rdata=%h err=%0b",
                 name, w ? "WR" : "RD", a, lat, resp_rdata, resp_error);
        check({name, "_latency"}, lat, 5);
        check({name, "_write"}, resp_write, w);
        check({name, "_rdata"}, resp_rdata, exp_d);
        check({name, "_error"}, resp_error, exp_e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check({name, "_hold_valid"}, resp_valid, 1'b1);
            check({name, "_hold_rdata"}, resp_rdata, exp_d);
            check({name, "_hold_ready"}, req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        check({name, "_post_valid"}, resp_valid, 1'b0);
        check({name, "_post_ready"}, req_ready, 1'b1);
    endtask

    localparam logic [127:0] W1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] W2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] WA = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;

    initial begin : main
        int n;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_write", resp_write, 1'b0);
        check("rst_resp_rdata", resp_rdata, 128'h0);
        check("rst_resp_error", resp_error, 1'b0);

        transact(1'b1, 32'h40, W1, '0, 1'b0, 0, "wr40");
        transact(1'b0, 32'h40, '0, W1, 1'b0, 7, "rd40_bp");
        transact(1'b1, 32'h44, W2, '0, 1'b0, 0, "wr44");
        transact(1'b0, 32'h40, '0, W2, 1'b0, 0, "rd40");
`ifdef MEM_RANGE_CHECK_EN
        transact(1'b0, 32'h0001_0000, '0, '0, 1'b1, 0, "rd_oor");
        transact(1'b1, 32'h0001_0040, W1, '0, 1'b1, 0, "wr_oor");
        transact(1'b0, 32'h40, '0, W2, 1'b0, 0, "rd40_after_oor");
`else
        transact(1'b0, 32'h40 + 32'd16384, '0, W2, 1'b0, 0, "rd_wrap");
`endif

        n = 0;
        while (!done1 && n < 500) begin
            @(posedge clock); n++;
        end
        check("lat1_done", done1, 1'b1);

        // Reset during the WAIT of a read drops it; the earlier write survives.
        transact(1'b1, 32'h80, WA, '0, 1'b0, 0, "wr80");
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h80;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midwait_rst_ready", req_ready, 1'b1);
        check("midwait_rst_valid", resp_valid, 1'b0);
        $display("txn %-14s RD addr=%08h dropped by reset", "rd80_reset", 32'h80);
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clock); #1;
            check("midwait_no_resp", resp_valid, 1'b0);
        end
        transact(1'b0, 32'h80, '0, WA, 1'b0, 0, "rd80");

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- LATENCY=1 back-to-back with resp_ready held high ----------------
    initial begin : lat1
        int n;
        int t;
        int tprev;
        bit w;
        logic [31:0] word;
        logic [127:0] line;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'h0; b_req_wdata = '0;
        b_resp_ready = 1'b1;
        tprev = 0;
        @(negedge reset);
        @(posedge clock); #1;
        b_req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w    = (k < 4);
            word = 32'hC0DE0000 + 32'(k % 4);
            line = {word, word, word, word};
            b_req_write = w;
            b_req_addr  = 32'((k % 4) * 16);
            b_req_wdata = w ? line : '0;
            n = 0;
            while (!b_req_ready && n < 20) begin
                @(posedge clock); #1; n++;
            end
            check("lat1_accept_wait", (n < 20), 1'b1);
            @(posedge clock); #1;
            t = cyc;
            if (k > 0) check("lat1_spacing", t - tprev, 3);
            tprev = t;
            check("lat1_valid_lag", b_resp_valid, 1'b0);
            @(posedge clock); #1;
            $display("txn %-14s %s addr=%08h rdata=%h", "lat1", w ? "WR" : "RD", b_req_addr, b_resp_rdata);
            check("lat1_valid", b_resp_valid, 1'b1);
            check("lat1_write", b_resp_write, w);
            check("lat1_rdata", b_resp_rdata, w ? 128'h0 : line);
            check("lat1_error", b_resp_error, 1'b0);
        end
        b_req_valid = 1'b0;
        @(posedge clock); #1;
        done1 = 1'b1;
    end

endmodule
